// File: rtl/imem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them to instruction
// memory, holding the processor in stall for the duration of the load.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_adr,
  output logic [31:0] wr_data,
  output logic        cpu_stall,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] adr_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  idx_reg;
  logic [31:0] word_reg;
  logic        err_reg;

  logic [33:0] end_adr;
  logic        misaligned;
  logic        out_of_range;
  logic        start_ok;
  logic        start_bad;
  logic        byte_acc;

  // End address is formed at 34 bits so a large base plus count cannot wrap.
  assign end_adr      = {2'b00, base_adr} + {16'b0, word_count, 2'b00};
  assign misaligned   = (base_adr[1:0] != 2'b00);
  assign out_of_range = (end_adr > 34'(MEM_BYTES));
  assign start_ok     = (state_reg == IDLE) && start && !misaligned && !out_of_range;
  assign start_bad    = (state_reg == IDLE) && start && (misaligned || out_of_range);
  assign byte_acc     = (state_reg == LOAD) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = (word_count == 16'd0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        if (byte_acc && (idx_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (cnt_reg == 16'd1) ? FINISH : LOAD;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == LOAD);
    wr_en     = (state_reg == WRITE);
    done      = (state_reg == FINISH);
    busy      = (state_reg != IDLE);
    cpu_stall = (state_reg != IDLE);
    error     = err_reg;
    wr_adr    = adr_reg;
    wr_data   = word_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_reg  <= 32'd0;
      cnt_reg  <= 16'd0;
      idx_reg  <= 2'd0;
      word_reg <= 32'd0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= start_bad;
      if (start_ok) begin
        adr_reg <= base_adr;
        cnt_reg <= word_count;
        idx_reg <= 2'd0;
      end
      if (byte_acc) begin
        word_reg[{idx_reg, 3'b000} +: 8] <= in_data;
        idx_reg                          <= idx_reg + 2'd1;
      end
      if (state_reg == WRITE) begin
        adr_reg <= adr_reg + 32'd4;
        cnt_reg <= cnt_reg - 16'd1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MEM_BYTES, default 65536, is the instruction memory size in bytes; a power of two and a multiple of 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 base_adr  input  32  byte address of the first word; sampled with start.
REQ-006 word_count  input  16  number of 32-bit words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high on a clock edge.
REQ-010 wr_en  output  1  one-cycle word write strobe to instruction memory.
REQ-011 wr_adr  output  32  byte address of the word write; always a multiple of 4.
REQ-012 wr_data  output  32  write word, little-endian: {byte3, byte2, byte1, byte0}.
REQ-013 cpu_stall  output  1  holds the processor PC and fetch while a load is in progress.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a load completes successfully.
REQ-016 error  output  1  one-cycle pulse when a load is rejected or aborted.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, WRITE, FINISH.
REQ-018 IDLE: start SHALL latch base_adr and word_count, clear the byte index and go to FINISH, or to LOAD when word_count is not 0; all other inputs are ignored.
REQ-019 Misaligned start (base_adr[1:0] != 0) SHALL produce an error pulse the next cycle with no writes, and the FSM SHALL stay in IDLE.
REQ-020 Out-of-range start (base_adr + 4*word_count > MEM_BYTES, computed at 33+ bits with no wrap) SHALL produce an error pulse with no writes, and the FSM SHALL stay in IDLE.
REQ-021 in_ready SHALL be high only in LOAD.
REQ-022 LOAD: byte k of the current word (k = 0..3, in arrival order) SHALL be stored in bits [8k+7:8k].
REQ-023 LOAD: acceptance of byte 3 SHALL move the FSM to WRITE on the next edge.
REQ-024 WRITE: wr_en SHALL be high for exactly one cycle, with wr_adr = the current address and wr_data = the assembled word.
REQ-025 WRITE: the current address SHALL then increase by 4 and the remaining word count SHALL decrease by 1.
REQ-026 WRITE: the FSM SHALL go next to FINISH when the remaining count reaches 0, otherwise to LOAD.
REQ-027 Latency: byte 3 accepted at edge N gives wr_en high in cycle N+1; in_ready SHALL be high again in cycle N+2.
REQ-028 Peak throughput SHALL be one word per 5 cycles; in_valid gaps SHALL stall LOAD indefinitely with no timeout.
REQ-029 FINISH: done SHALL pulse for one cycle, then the FSM returns to IDLE.
REQ-030 cpu_stall SHALL equal busy; cpu_stall and busy SHALL drop in the cycle after FINISH.
REQ-031 start asserted while busy SHALL be ignored and SHALL NOT affect the latched parameters.
REQ-032 wr_en, done and error SHALL never be high in the same cycle.
REQ-033 word_count = 0 with a valid base_adr SHALL produce a done pulse with no wr_en and no byte consumed.
REQ-034 A load ending exactly at address MEM_BYTES-4 SHALL be legal and SHALL complete with done.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE.
REQ-036 rst_n low SHALL immediately force in_ready, wr_en, cpu_stall, busy, done and error to 0.
REQ-037 rst_n low SHALL immediately clear wr_adr, wr_data, the byte index and the remaining count to 0.
REQ-038 Reset during a load SHALL discard any partial word, issue no further write, and require a new start.

Verification
REQ-039 start with base_adr=0, word_count=2, bytes 23,01,E8,03,09,00,02,20 -> two writes: adr 0 data 0x03E80123, then adr 4 data 0x20020009; done pulse 1 cycle after the second write; cpu_stall high from the cycle after start through FINISH.
REQ-040 start with base_adr=0x102, word_count=1 -> error pulse next cycle; no wr_en, busy stays 0, in_ready stays 0.
REQ-041 start with base_adr=0xFFFC, word_count=1, MEM_BYTES=65536 -> one write to 0xFFFC, then done; base_adr=0xFFFC, word_count=2 -> error pulse, no write.
REQ-042 word_count=0 -> done pulse, no wr_en; in_valid held high and no byte accepted.
REQ-043 Random in_valid gaps over 16 words -> byte order preserved; wr_adr steps base, base+4, ... base+60; a second start mid-load has no effect.
REQ-044 rst_n low after byte 2 of word 3 -> all outputs 0 immediately, no write of the partial word; a new load after rst_n rises completes normally.
